// File: rtl/instruction_cj_encoder_pkg.sv
// Shared constants and types for the JAL -> c.j/c.jal packer.
// Used by the compressor and the packing top level.
package instruction_cj_encoder_pkg;

  localparam logic [6:0]  JAL      = 7'b1101111;
  localparam logic [2:0]  F3_CJ    = 3'b101;
  localparam logic [2:0]  F3_CJAL  = 3'b001;
  localparam logic [1:0]  QUAD_C1  = 2'b01;
  localparam logic [15:0] C_NOP    = 16'h0001;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/instruction_cj_encoder_cj_compress.sv
// Combinational check and encoder: JAL x0/x1 with a
// 12-bit reachable offset becomes c.j / c.jal.
import instruction_cj_encoder_pkg::*;

module cj_compress (
  input  logic [31:0] instr,
  output logic        is_c,
  output logic [15:0] c16
);

  logic       op_ok;
  logic       rd_ok;
  logic       imm_ok;
  logic [8:0] upper;

  // instr[31] is imm[20], instr[19:12] is imm[19:12],
  // instr[20] is imm[11]
  assign upper  = {instr[31], instr[19:12]};
  assign op_ok  = instr[6:0] == JAL;
  assign rd_ok  = instr[11:8] == 4'd0;
  assign imm_ok = upper == {9{instr[20]}};
  assign is_c   = op_ok && rd_ok && imm_ok;

  // rd bit 7 selects c.jal (ra) over c.j (x0)
  assign c16 = {
    instr[7] ? F3_CJAL : F3_CJ,
    instr[20],
    instr[24],
    instr[29:28],
    instr[30],
    instr[26],
    instr[27],
    instr[23:21],
    instr[25],
    QUAD_C1
  };

endmodule

// File: rtl/instruction_cj_encoder.sv
// Compresses eligible JALs and packs the resulting
// 16/32-bit stream into aligned 32-bit words.
import instruction_cj_encoder_pkg::*;

module instruction_cj_encoder (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iVALID,
  input  logic [31:0] iINSTR,
  output logic        oREADY,
  input  logic        iFLUSH,
  output logic        oVALID,
  output logic [31:0] oWORD,
  input  logic        iREADY,
  output logic        oHALF,
  output logic [15:0] oCOMP_CNT
);

  pack_state_t state;
  logic [15:0] half_q;
  logic        is_c;
  logic [15:0] c16;
  logic        can_load;
  logic        flush_go;
  logic        acc;

  cj_compress u_comp (
    .instr (iINSTR),
    .is_c  (is_c),
    .c16   (c16)
  );

  assign can_load = !oVALID || iREADY;
  assign flush_go = can_load && iFLUSH && (state == HALF);
  assign oREADY   = can_load && !(iFLUSH && (state == HALF));
  assign acc      = iVALID && oREADY;
  assign oHALF    = state == HALF;

  // Packer state, held halfword and the single output register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= EMPTY;
      half_q <= 16'h0000;
      oVALID <= 1'b0;
      oWORD  <= 32'h0;
    end else if (flush_go) begin
      oWORD  <= {C_NOP, half_q};
      oVALID <= 1'b1;
      state  <= EMPTY;
    end else if (acc) begin
      unique case (1'b1)
        is_c && state == EMPTY: begin
          half_q <= c16;
          state  <= HALF;
          oVALID <= 1'b0;
        end
        is_c && state == HALF: begin
          oWORD  <= {c16, half_q};
          oVALID <= 1'b1;
          state  <= EMPTY;
        end
        !is_c && state == EMPTY: begin
          oWORD  <= iINSTR;
          oVALID <= 1'b1;
        end
        default: begin
          oWORD  <= {iINSTR[15:0], half_q};
          half_q <= iINSTR[31:16];
          oVALID <= 1'b1;
        end
      endcase
    end else if (can_load) begin
      oVALID <= 1'b0;
    end
  end

  // Saturating count of instructions sent compressed
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oCOMP_CNT <= 16'h0000;
    end else if (acc && is_c && oCOMP_CNT != 16'hFFFF) begin
      oCOMP_CNT <= oCOMP_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_cj_encoder.sv
// Bench: halfword-stream reference model, random and
// directed stimulus for instruction_cj_encoder.
module tb_instruction_cj_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] instr;
  logic        o_ready;
  logic        flush;
  logic        o_valid;
  logic [31:0] o_word;
  logic        dready;
  logic        o_half;
  logic [15:0] o_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] pend[$];
  logic [31:0] exp_q[$];
  logic [15:0] mcnt;

  always #5 clk = ~clk;

  instruction_cj_encoder dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iVALID    (valid),
    .iINSTR    (instr),
    .oREADY    (o_ready),
    .iFLUSH    (flush),
    .oVALID    (o_valid),
    .oWORD     (o_word),
    .iREADY    (dready),
    .oHALF     (o_half),
    .oCOMP_CNT (o_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  // Reference: offset range decides compressibility
  function automatic logic [16:0] ref_c(
    input logic [31:0] i);
    logic [20:0] imm;
    int          off;
    logic        ok;
    logic [2:0]  f3;
    imm = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    off = int'($signed(imm));
    ok  = (i[6:0] == 7'h6F) && (i[11:7] < 5'd2)
          && off >= -2048 && off <= 2046;
    f3  = (i[11:7] == 5'd1) ? 3'b001 : 3'b101;
    return {ok, f3, imm[11], imm[4], imm[9:8],
            imm[10], imm[6], imm[7], imm[3:1],
            imm[5], 2'b01};
  endfunction

  function automatic logic [31:0] mk_jal(
    input int off, input logic [4:0] rd);
    logic [20:0] imm;
    imm = off[20:0];
    return {imm[20], imm[10:1], imm[11],
            imm[19:12], rd, 7'h6F};
  endfunction

  task automatic model_clear();
    pend.delete();
    exp_q.delete();
    mcnt = 16'h0;
  endtask

  task automatic cycle(input logic v,
                       input logic [31:0] ins,
                       input logic fl,
                       input logic rdy);
    logic        exp_rdy;
    logic        produced;
    logic        held;
    logic [31:0] hold_word;
    logic [16:0] r;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [31:0] e;
    produced = 1'b0;
    held = 1'b0;
    hold_word = 32'h0;
    @(negedge clk);
    valid = v;
    instr = ins;
    flush = fl;
    dready = rdy;
    #1;
    exp_rdy = (!o_valid || rdy)
              && !(fl && pend.size() == 1);
    check("ready", {31'b0, o_ready}, {31'b0, exp_rdy});
    if (o_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_word", o_word, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check("word", o_word, e);
      end
    end
    if (o_valid && !rdy) begin
      held = 1'b1;
      hold_word = o_word;
    end
    if (fl && pend.size() == 1 && (!o_valid || rdy)) begin
      pend.push_back(16'h0001);
    end else if (v && exp_rdy) begin
      r = ref_c(ins);
      if (r[16]) begin
        pend.push_back(r[15:0]);
        if (mcnt != 16'hFFFF) mcnt++;
      end else begin
        pend.push_back(ins[15:0]);
        pend.push_back(ins[31:16]);
      end
    end
    if (pend.size() >= 2) begin
      lo = pend.pop_front();
      hi = pend.pop_front();
      exp_q.push_back({hi, lo});
      produced = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid", {31'b0, o_valid},
          {31'b0, produced || held});
    if (held) check("stable", o_word, hold_word);
    check("half", {31'b0, o_half},
          {31'b0, pend.size() == 1});
    check("count", {16'b0, o_cnt}, {16'b0, mcnt});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 32'h0, 0, 1);
  endtask

  initial begin
    int          sel;
    int          off;
    logic [31:0] w;
    logic        bad;
    rst_n = 1'b0;
    valid = 1'b0;
    instr = 32'h0;
    flush = 1'b0;
    dready = 1'b1;
    model_clear();
    #12;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_word", o_word, 32'h0);
    check("rst_half", {31'b0, o_half}, 32'd0);
    check("rst_cnt", {16'b0, o_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'b0, o_ready}, 32'd1);

    // c.j then c.jal pack into one word
    cycle(1, 32'h0080006F, 0, 1);
    check("cj_half", {31'b0, o_half}, 32'd1);
    check("cj_noout", {31'b0, o_valid}, 32'd0);
    cycle(1, 32'h008000EF, 0, 1);
    check("cj_pair", o_word, 32'h2021A021);
    check("cj_cnt", {16'b0, o_cnt}, 32'd2);
    idle(1);

    // negative offset then flush with c.nop
    cycle(1, 32'hFFFFF06F, 0, 1);
    cycle(0, 32'h0, 1, 1);
    check("flush_word", o_word, 32'h0001BFFD);
    check("flush_half", {31'b0, o_half}, 32'd0);
    idle(1);

    // non-compressible pass through
    cycle(1, 32'h0010006F, 0, 1);
    check("pass_far", o_word, 32'h0010006F);
    cycle(1, 32'h008002EF, 0, 1);
    check("pass_rd5", o_word, 32'h008002EF);
    cycle(1, 32'h00000013, 0, 1);
    check("pass_nop", o_word, 32'h00000013);
    check("pass_cnt", {16'b0, o_cnt}, 32'd3);
    idle(1);

    // 32-bit straddles held halfword
    cycle(1, 32'h0080006F, 0, 1);
    cycle(1, 32'h00000013, 0, 1);
    check("mix_word", o_word, 32'h0013A021);
    check("mix_half", {31'b0, o_half}, 32'd1);
    cycle(0, 32'h0, 1, 1);
    check("mix_flush", o_word, 32'h00010000);

    // backpressure, then flush racing input in HALF
    cycle(1, 32'h0080006F, 0, 1);
    cycle(1, 32'h00000013, 0, 0);
    cycle(1, 32'h0000_0093, 0, 0);
    cycle(1, 32'h0000_0093, 0, 0);
    cycle(1, 32'h0080006F, 1, 1);
    check("race_flush", o_word, 32'h00010000);
    cycle(1, 32'h0080006F, 0, 1);
    check("race_after", {31'b0, o_half}, 32'd1);

    // async reset with a halfword held
    cycle(0, 32'h0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", {31'b0, o_valid}, 32'd0);
    check("mid_half", {31'b0, o_half}, 32'd0);
    check("mid_cnt", {16'b0, o_cnt}, 32'd0);
    check("mid_word", o_word, 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 32'h0080006F, 0, 1);
    cycle(1, 32'hFFFFF06F, 0, 1);
    check("post_rst", o_word, 32'hBFFDA021);

    // randomized mix
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin
          off = int'($urandom_range(0, 2047)) * 2 - 2048;
          w = mk_jal(off, 5'($urandom_range(0, 2)));
        end
        1: begin
          off = int'($urandom_range(0, 1048575)) * 2
                - 1048576;
          w = mk_jal(off, 5'($urandom_range(0, 1)));
        end
        default: w = $urandom;
      endcase
      cycle($urandom_range(0, 3) != 0, w,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0);
    end
    cycle(0, 32'h0, 1, 1);
    idle(3);
    check("drain", exp_q.size(), 32'd0);

    // counter saturation
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    instr = 32'h0080006F;
    flush = 1'b0;
    dready = 1'b1;
    bad = 1'b0;
    repeat (65540) begin
      @(posedge clk);
      if (!o_ready) bad = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    #1;
    check("sat_ready", {31'b0, bad}, 32'd0);
    check("sat_cnt", {16'b0, o_cnt}, 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
